// File: rtl/imm_gen_if.sv
// imm_gen_if: valid/ready handshake bundle between decode and the immediate-generator stage
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [2:0]       in_extop;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output in_valid, in_inst, in_extop, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag
  );
  modport slave (
    input  in_valid, in_inst, in_extop, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag
  );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RV32I/RV64I immediate generator behind a 2-entry skid buffer
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic      clk,
  input logic      rst_n,
  input logic      flush_i,
  imm_gen_if.slave bus
);
  localparam logic [2:0] EXT_I  = 3'b000;
  localparam logic [2:0] EXT_B  = 3'b001;
  localparam logic [2:0] EXT_J  = 3'b010;
  localparam logic [2:0] EXT_S  = 3'b011;
  localparam logic [2:0] EXT_U  = 3'b100;
  localparam logic [2:0] EXT_Z  = 3'b101;
  localparam logic [2:0] EXT_SH = 3'b110;
  logic [31:0]      inst;
  logic             s;
  logic [63:0]      imm_full;
  logic [XLEN-1:0]  imm_new;
  logic             unused_bits;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
  logic             accept, main_free, load_main, load_skid;
  assign inst = bus.in_inst;
  assign s    = inst[31];
  // Built at 64 bits and truncated, so one expression serves both XLEN values
  always_comb begin
    imm_full = bus.in_extop == EXT_I  ? {{52{s}}, inst[31:20]} :
               bus.in_extop == EXT_B  ? {{51{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
               bus.in_extop == EXT_J  ? {{43{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
               bus.in_extop == EXT_S  ? {{52{s}}, inst[31:25], inst[11:7]} :
               bus.in_extop == EXT_U  ? {{32{s}}, inst[31:12], 12'b0} :
               bus.in_extop == EXT_Z  ? {59'b0, inst[19:15]} :
               bus.in_extop == EXT_SH ? (XLEN == 64 ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]}) :
               64'b0;
  end
  assign imm_new     = imm_full[XLEN-1:0];
  assign unused_bits = ^{inst[6:0], imm_full};
  always_comb begin
    accept       = bus.in_valid && !skid_valid_q;
    main_free    = !main_valid_q || bus.out_ready;
    load_main    = !flush_i && main_free && (skid_valid_q || accept);
    load_skid    = !flush_i && !main_free && accept;
    main_valid_d = !flush_i && (!main_free || skid_valid_q || accept);
    skid_valid_d = !flush_i && !main_free && (skid_valid_q || accept);
    main_imm_d   = load_main ? (skid_valid_q ? skid_imm_q : imm_new) : main_imm_q;
    main_tag_d   = load_main ? (skid_valid_q ? skid_tag_q : bus.in_tag) : main_tag_q;
    skid_imm_d   = load_skid ? imm_new : skid_imm_q;
    skid_tag_d   = load_skid ? bus.in_tag : skid_tag_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
    end
  end
  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = main_valid_q;
  assign bus.out_imm   = main_imm_q;
  assign bus.out_tag   = main_tag_q;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: randomized and directed checks of imm_gen_stage against an arithmetic reference model
module tb_imm_gen_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  imm_gen_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_if #(.XLEN(64), .TAG_W(32)) b64 ();
  imm_gen_stage #(.XLEN(32), .TAG_W(32)) u32 (.clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(b32));
  imm_gen_stage #(.XLEN(64), .TAG_W(32)) u64 (.clk(clk), .rst_n(rst_n), .flush_i(1'b0), .bus(b64));

  function automatic longint sx(input longint x, input int n);
    return x >= (longint'(1) << (n - 1)) ? x - (longint'(1) << n) : x;
  endfunction

  // Immediate value as the signed integer each format denotes, then wrapped to xl bits
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] op, input int xl);
    longint v;
    case (op)
      3'd0: v = sx(longint'(i >> 20), 12);
      3'd1: v = sx(longint'((((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) | (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1)), 13);
      3'd2: v = sx(longint'((((i >> 31) & 1) << 20) | (((i >> 12) & 255) << 12) | (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1)), 21);
      3'd3: v = sx(longint'((((i >> 25) & 127) << 5) | ((i >> 7) & 31)), 12);
      3'd4: v = sx(longint'(i & 32'hFFFFF000), 32);
      3'd5: v = longint'((i >> 15) & 31);
      3'd6: v = longint'((i >> 20) & (xl == 64 ? 63 : 31));
      default: v = 0;
    endcase
    return xl == 64 ? v : (v & 64'hFFFF_FFFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (b32.out_valid !== 1'b0) $display("FAIL reset_valid32 got %b want 0", b32.out_valid); else passed++;
    checks++; if (b32.out_imm !== 32'h0) $display("FAIL reset_imm32 got %h want 0", b32.out_imm); else passed++;
    checks++; if (b32.out_tag !== 32'h0) $display("FAIL reset_tag32 got %h want 0", b32.out_tag); else passed++;
    checks++; if (b32.in_ready !== 1'b1) $display("FAIL reset_ready32 got %b want 1", b32.in_ready); else passed++;
    checks++; if (b64.out_valid !== 1'b0) $display("FAIL reset_valid64 got %b want 0", b64.out_valid); else passed++;
    checks++; if (b64.out_imm !== 64'h0) $display("FAIL reset_imm64 got %h want 0", b64.out_imm); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_formats32();
    logic [31:0] insts [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h0010006F, 32'hFE112E23, 32'h000FD073, 32'h01F09093};
    logic [2:0]  ops   [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110};
    logic [31:0] exps  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000800, 32'hFFFFFFFC, 32'h0000001F, 32'h0000001F};
    b32.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b32.in_valid = 1'b1;
      b32.in_inst  = insts[k];
      b32.in_extop = ops[k];
      b32.in_tag   = 32'(k + 16);
      tick();
      checks++; if (b32.out_valid !== 1'b1) $display("FAIL fmt%0d_valid got %b want 1", k, b32.out_valid); else passed++;
      checks++; if (b32.out_imm !== exps[k]) $display("FAIL fmt%0d_imm got %h want %h", k, b32.out_imm, exps[k]); else passed++;
      checks++; if (b32.out_tag !== 32'(k + 16)) $display("FAIL fmt%0d_tag got %0d want %0d", k, b32.out_tag, k + 16); else passed++;
    end
    b32.in_valid = 1'b0;
    tick();
    checks++; if (b32.out_valid !== 1'b0) $display("FAIL fmt_drain got %b want 0", b32.out_valid); else passed++;
  endtask

  task automatic test_u_format64();
    logic [31:0] insts [2] = '{32'h123450B7, 32'h80000037};
    logic [63:0] exps  [2] = '{64'h0000000012345000, 64'hFFFFFFFF80000000};
    b64.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b64.in_valid = 1'b1;
      b64.in_inst  = insts[k];
      b64.in_extop = 3'b100;
      b64.in_tag   = 32'(k + 32);
      tick();
      checks++; if (b64.out_valid !== 1'b1) $display("FAIL u64_%0d_valid got %b want 1", k, b64.out_valid); else passed++;
      checks++; if (b64.out_imm !== exps[k]) $display("FAIL u64_%0d_imm got %h want %h", k, b64.out_imm, exps[k]); else passed++;
    end
    b64.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back64();
    logic [63:0] exp_imm;
    logic [31:0] exp_tag;
    b64.out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      b64.in_valid = 1'b1;
      b64.in_inst  = $urandom;
      b64.in_extop = 3'($urandom);
      b64.in_tag   = $urandom;
      exp_imm = ref_imm(b64.in_inst, b64.in_extop, 64);
      exp_tag = b64.in_tag;
      checks++; if (b64.in_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", b64.in_ready); else passed++;
      tick();
      checks++; if (b64.out_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", b64.out_valid); else passed++;
      checks++; if (b64.out_imm !== exp_imm) $display("FAIL b2b_imm op=%0d got %h want %h", b64.in_extop, b64.out_imm, exp_imm); else passed++;
      checks++; if (b64.out_tag !== exp_tag) $display("FAIL b2b_tag got %h want %h", b64.out_tag, exp_tag); else passed++;
    end
    b64.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] qt [$];
    logic [63:0] qi [$];
    int next = 1;
    int got = 0;
    int first_stall = 0;
    logic acc, con, stalled;
    logic [31:0] held_imm, held_tag;
    stalled = 1'b0;
    for (int c = 1; c <= 20 && got < 6; c++) begin
      b32.out_ready = !(c >= 3 && c <= 5);
      b32.in_valid  = next <= 6;
      b32.in_tag    = 32'(next);
      b32.in_inst   = $urandom;
      b32.in_extop  = 3'($urandom);
      if (first_stall != 0 && c == first_stall + 1) begin
        checks++; if (b32.in_ready !== 1'b0) $display("FAIL bp_ready_fall got %b want 0", b32.in_ready); else passed++;
      end
      checks++; if (b32.in_ready !== (qt.size() < 2)) $display("FAIL bp_ready c=%0d got %b want %b", c, b32.in_ready, qt.size() < 2); else passed++;
      checks++; if (b32.out_valid !== (qt.size() > 0)) $display("FAIL bp_valid c=%0d got %b want %b", c, b32.out_valid, qt.size() > 0); else passed++;
      if (stalled) begin
        checks++; if (b32.out_imm !== held_imm || b32.out_tag !== held_tag) $display("FAIL bp_hold got %h/%0d want %h/%0d", b32.out_imm, b32.out_tag, held_imm, held_tag); else passed++;
      end
      acc = b32.in_valid && b32.in_ready;
      con = b32.out_valid && b32.out_ready;
      stalled  = b32.out_valid && !b32.out_ready;
      held_imm = b32.out_imm;
      held_tag = b32.out_tag;
      if (con && qt.size() > 0) begin
        checks++; if (b32.out_tag !== qt[0]) $display("FAIL bp_order got %0d want %0d", b32.out_tag, qt[0]); else passed++;
        checks++; if ({32'b0, b32.out_imm} !== qi[0]) $display("FAIL bp_imm got %h want %h", b32.out_imm, qi[0][31:0]); else passed++;
        void'(qt.pop_front());
        void'(qi.pop_front());
        got++;
      end
      if (acc) begin
        qt.push_back(b32.in_tag);
        qi.push_back(ref_imm(b32.in_inst, b32.in_extop, 32));
        if (stalled && first_stall == 0) first_stall = c;
        next++;
      end
      tick();
    end
    b32.in_valid = 1'b0;
    checks++; if (got !== 6) $display("FAIL bp_count got %0d want 6", got); else passed++;
    checks++; if (first_stall !== 3) $display("FAIL bp_first_stall got %0d want 3", first_stall); else passed++;
    tick();
  endtask

  task automatic test_flush();
    b32.out_ready = 1'b0;
    b32.in_valid  = 1'b1;
    b32.in_inst   = 32'hFFF00093;
    b32.in_extop  = 3'b000;
    b32.in_tag    = 32'hA1;
    tick();
    b32.in_tag = 32'hA2;
    tick();
    checks++; if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) $display("FAIL flush_full got rdy=%b vld=%b want 0/1", b32.in_ready, b32.out_valid); else passed++;
    flush = 1'b1;
    b32.in_tag = 32'hA3;
    tick();
    flush = 1'b0;
    b32.in_valid = 1'b0;
    checks++; if (b32.out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", b32.out_valid); else passed++;
    checks++; if (b32.in_ready !== 1'b1) $display("FAIL flush_ready got %b want 1", b32.in_ready); else passed++;
    b32.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (b32.out_valid !== 1'b0) $display("FAIL flush_ghost tag=%h got %b want 0", b32.out_tag, b32.out_valid); else passed++;
    end
    b32.in_valid = 1'b1;
    b32.in_tag   = 32'hA4;
    tick();
    b32.in_valid = 1'b0;
    checks++; if (b32.out_valid !== 1'b1 || b32.out_tag !== 32'hA4) $display("FAIL flush_after got %b/%h want 1/a4", b32.out_valid, b32.out_tag); else passed++;
    tick();
  endtask

  task automatic test_random_stream();
    logic [31:0] qt [$];
    logic [63:0] qi [$];
    logic acc, con;
    for (int c = 0; c < 400; c++) begin
      b32.in_valid  = $urandom_range(3) != 0;
      b32.out_ready = $urandom_range(2) != 0;
      flush         = $urandom_range(19) == 0;
      b32.in_inst   = $urandom;
      b32.in_extop  = 3'($urandom);
      b32.in_tag    = $urandom;
      checks++; if (b32.in_ready !== (qt.size() < 2)) $display("FAIL rnd_ready c=%0d got %b want %b", c, b32.in_ready, qt.size() < 2); else passed++;
      checks++; if (b32.out_valid !== (qt.size() > 0)) $display("FAIL rnd_valid c=%0d got %b want %b", c, b32.out_valid, qt.size() > 0); else passed++;
      acc = b32.in_valid && b32.in_ready;
      con = b32.out_valid && b32.out_ready;
      if (con && qt.size() > 0) begin
        checks++; if (b32.out_tag !== qt[0]) $display("FAIL rnd_tag c=%0d got %h want %h", c, b32.out_tag, qt[0]); else passed++;
        checks++; if ({32'b0, b32.out_imm} !== qi[0]) $display("FAIL rnd_imm c=%0d got %h want %h", c, b32.out_imm, qi[0][31:0]); else passed++;
      end
      if (flush) begin
        qt.delete();
        qi.delete();
      end else begin
        if (con && qt.size() > 0) begin
          void'(qt.pop_front());
          void'(qi.pop_front());
        end
        if (acc) begin
          qt.push_back(b32.in_tag);
          qi.push_back(ref_imm(b32.in_inst, b32.in_extop, 32));
        end
      end
      tick();
    end
    flush = 1'b0;
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    b32.out_ready = 1'b0;
    b32.in_valid  = 1'b1;
    b32.in_inst   = 32'hFFF00093;
    b32.in_extop  = 3'b000;
    b32.in_tag    = 32'hB1;
    tick();
    b32.in_valid = 1'b0;
    checks++; if (b32.out_valid !== 1'b1) $display("FAIL rstmid_pre got %b want 1", b32.out_valid); else passed++;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (b32.out_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", b32.out_valid); else passed++;
    checks++; if (b32.out_imm !== 32'h0) $display("FAIL rstmid_imm got %h want 0", b32.out_imm); else passed++;
    checks++; if (b32.out_tag !== 32'h0) $display("FAIL rstmid_tag got %h want 0", b32.out_tag); else passed++;
    checks++; if (b32.in_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", b32.in_ready); else passed++;
    #3;
    rst_n = 1'b1;
    tick();
    b32.out_ready = 1'b1;
    b32.in_valid  = 1'b1;
    b32.in_inst   = 32'h0010006F;
    b32.in_extop  = 3'b010;
    b32.in_tag    = 32'hB2;
    tick();
    b32.in_valid = 1'b0;
    checks++; if (b32.out_valid !== 1'b1 || b32.out_tag !== 32'hB2) $display("FAIL rstmid_after got %b/%h want 1/b2", b32.out_valid, b32.out_tag); else passed++;
    checks++; if (b32.out_imm !== 32'h00000800) $display("FAIL rstmid_after_imm got %h want 00000800", b32.out_imm); else passed++;
    tick();
  endtask

  initial begin
    b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_extop = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_extop = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
    test_reset();
    test_formats32();
    test_u_format64();
    test_back_to_back64();
    test_backpressure();
    test_flush();
    test_random_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
